// File: rtl/wave_gen.sv
// wave_gen: periodic waveform generator (sine, triangle, sawtooth, square).
// One period is N = 2^ADDR_W phase steps. Each step is held period_sel+1
// cycles. The sine is built from a quarter-wave table using symmetry.
// Optional feature macro: WAVE_GEN_CONT_EN adds a 'cont' input. While cont
// is high the generator starts from IDLE and restarts at the end of every
// period. Without the macro each en request produces a single period.
`timescale 1ns/1ps

module wave_gen #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              en,
  input  logic [SEL_W-1:0]  period_sel,
  input  logic [1:0]        mode,
`ifdef WAVE_GEN_CONT_EN
  input  logic              cont,
`endif
  output logic [DATA_W-1:0] sin_out,
  output logic              busy,
  output logic              done
);

  localparam int N  = 32'd1 << ADDR_W;
  localparam int Q  = N / 32'd4;
  localparam int SH = DATA_W - ADDR_W;
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'((32'd1 << (DATA_W - 1)) - 32'd1);

  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] K_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-2:0] Q_IDX  = {1'b1, {(ADDR_W-2){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [SEL_W-1:0]    hold_q, hold_d;
  logic [SEL_W-1:0]    psel_q, psel_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   sin_out_q, sin_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_s;
  logic [DATA_W-1:0]   qtab_s [0:Q];
  logic [ADDR_W-2:0]   fwd_idx_s, rev_idx_s;
  logic [DATA_W-1:0]   tab_s, sine_s, tri_s, saw_s, sq_s, sample_s;
  logic [ADDR_W:0]     tk_s, tk_inv_s;

`ifdef WAVE_GEN_CONT_EN
  assign start_s = en | cont;
`else
  assign start_s = en;
`endif

  // Quarter-wave table: entry i = round(AMP * sin(pi/2 * i/Q)), i = 0..Q.
  for (genvar gi = 0; gi <= Q; gi++) begin : g_qtab
    localparam real ANG = PI * real'(gi) / real'(2 * Q);
    localparam logic [DATA_W-1:0] QV = DATA_W'($rtoi(AMP * $sin(ANG) + 0.5));
    assign qtab_s[gi] = QV;
  end

  // Sequencing: start/latch in IDLE, hold/advance/wrap in RUN, done at period end.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    psel_d  = psel_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        k_d    = '0;
        hold_d = '0;
        if (start_s) begin
          state_d = RUN;
          psel_d  = period_sel;
          mode_d  = mode;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hold_q != psel_q) begin
          hold_d = hold_q + SEL_W'(1'b1);
        end else begin
          hold_d = '0;
          if (k_q != K_LAST) begin
            k_d = k_q + ADDR_W'(1'b1);
          end else begin
            // End of period: either re-latch and wrap, or fall back to IDLE.
            done_d = 1'b1;
            k_d    = '0;
            if (start_s) begin
              state_d = RUN;
              psel_d  = period_sel;
              mode_d  = mode;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Sample for the phase/mode that will be current after the next edge.
  always_comb begin
    fwd_idx_s = {1'b0, k_d[ADDR_W-3:0]};
    rev_idx_s = Q_IDX - fwd_idx_s;
    // Odd quadrants run the quarter table backwards.
    if (k_d[ADDR_W-2]) begin
      tab_s = qtab_s[rev_idx_s];
    end else begin
      tab_s = qtab_s[fwd_idx_s];
    end
    // Second half of the period is the negated first half.
    if (k_d[ADDR_W-1]) begin
      sine_s = MID - tab_s;
    end else begin
      sine_s = MID + tab_s;
    end
    tk_s     = {k_d, 1'b0};
    tk_inv_s = ~tk_s;
    if (k_d[ADDR_W-1]) begin
      tri_s = DATA_W'(tk_inv_s) << SH;
      sq_s  = '0;
    end else begin
      tri_s = DATA_W'(tk_s) << SH;
      sq_s  = '1;
    end
    saw_s = DATA_W'(k_d) << SH;
    case (mode_d)
      2'd0:    sample_s = sine_s;
      2'd1:    sample_s = tri_s;
      2'd2:    sample_s = saw_s;
      2'd3:    sample_s = sq_s;
      default: sample_s = MID;
    endcase
    if (state_d == RUN) begin
      sin_out_d = sample_s;
      busy_d    = 1'b1;
    end else begin
      sin_out_d = MID;
      busy_d    = 1'b0;
    end
  end

  // State and registered outputs; reset aborts any period without a done pulse.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q   <= IDLE;
      k_q       <= '0;
      hold_q    <= '0;
      psel_q    <= '0;
      mode_q    <= 2'd0;
      sin_out_q <= MID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      hold_q    <= hold_d;
      psel_q    <= psel_d;
      mode_q    <= mode_d;
      sin_out_q <= sin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sin_out = sin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: directed scenarios plus randomized
// chains of periods, compared against an arithmetic reference of the waveforms.
`timescale 1ns/1ps

module tb_wave_gen;

  localparam int DW  = 9;
  localparam int AW  = 8;
  localparam int SW  = 8;
  localparam int N   = 256;
  localparam int MID = 256;
  localparam int S   = 2;

  logic          clk = 1'b0;
  logic          resetb;
  logic          en;
  logic [SW-1:0] period_sel;
  logic [1:0]    mode;
  logic [DW-1:0] sin_out;
  logic          busy;
  logic          done;
`ifdef WAVE_GEN_CONT_EN
  logic          cont;
  bit            drive_cont = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wave_gen #(.DATA_W(DW), .ADDR_W(AW), .SEL_W(SW)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .en         (en),
    .period_sel (period_sel),
    .mode       (mode),
`ifdef WAVE_GEN_CONT_EN
    .cont       (cont),
`endif
    .sin_out    (sin_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waveform value at phase k, straight from the defining formulas.
  function automatic int ref_sample(input int m, input int k);
    real v;
    int  r;
    case (m)
      0: begin
        v = real'(MID - 1) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return MID + r;
      end
      1:       return (k < N/2) ? 2*k*S : (2*N - 1 - 2*k) * S;
      2:       return k * S;
      default: return (k < N/2) ? (1 << DW) - 1 : 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int m, input int p, input bit keep);
    en         = 1'b1;
    mode       = 2'(m);
    period_sel = SW'(p);
    tick();
    if (!keep) en = 1'b0;
  endtask

  // Checks one period cycle by cycle, scrambles inputs mid-run, and arranges
  // the continuation (or not) at the end. Entered #1 after the start/wrap edge.
  task automatic run_period(input int m, input int p, input bit first_done,
                            input bit cont_next, input int next_m, input int next_p,
                            input int abort_at);
    int len;
    len = N * (p + 1);
    for (int c = 0; c < len; c++) begin
      int k;
      k = c / (p + 1);
      if (c == abort_at) return;
      chk($sformatf("sample m%0d p%0d c%0d", m, p, c), 32'(sin_out), ref_sample(m, k));
      chk($sformatf("busy c%0d", c), 32'(busy), 1);
      chk($sformatf("done c%0d", c), 32'(done), (c == 0 && first_done) ? 1 : 0);
      if (m == 0 && (c % (p + 1)) == 0 && (k % 64) == 0)
        chk($sformatf("sine_point k%0d", k), 32'(sin_out), (k == 64) ? 511 : (k == 192) ? 1 : 256);
      if (c == len / 2) begin
        mode       = 2'($urandom);
        period_sel = SW'($urandom);
`ifdef WAVE_GEN_CONT_EN
        if (drive_cont) cont = cont_next;
`endif
      end
      if (c == len - 1) begin
        if (cont_next) begin
          mode       = 2'(next_m);
          period_sel = SW'(next_p);
        end
`ifdef WAVE_GEN_CONT_EN
        if (!drive_cont) en = cont_next;
`else
        en = cont_next;
`endif
      end
      tick();
    end
    if (!cont_next) begin
      chk("done_at_end", 32'(done), 1);
      chk("idle_sin", 32'(sin_out), MID);
      chk("idle_busy", 32'(busy), 0);
      tick();
      chk("done_clear", 32'(done), 0);
      chk("idle_sin2", 32'(sin_out), MID);
      chk("idle_busy2", 32'(busy), 0);
    end
  endtask

  initial begin
    int  cm, cp, nm, np;
    bit  cn, fd;
    resetb     = 1'b1;
    en         = 1'b0;
    mode       = 2'd0;
    period_sel = '0;
`ifdef WAVE_GEN_CONT_EN
    cont       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sin", 32'(sin_out), MID);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    #3 resetb = 1'b0;
    repeat (3) begin
      tick();
      chk("post_reset_idle_sin", 32'(sin_out), MID);
      chk("post_reset_idle_busy", 32'(busy), 0);
    end

    // Single sine period, one cycle per sample.
    start(0, 0, 1'b0);
    run_period(0, 0, 1'b0, 1'b0, 0, 0, -1);

    // Sawtooth with three cycles per sample; inputs scrambled mid-run.
    start(2, 2, 1'b0);
    run_period(2, 2, 1'b0, 1'b0, 0, 0, -1);

    // Triangle with en held high across the period boundary.
    start(1, 0, 1'b1);
    run_period(1, 0, 1'b0, 1'b1, 1, 0, -1);
    run_period(1, 0, 1'b1, 1'b0, 0, 0, -1);

    // Square aborted by reset at k=100.
    start(3, 0, 1'b0);
    run_period(3, 0, 1'b0, 1'b0, 0, 0, 100);
    #2 resetb = 1'b1;
    #1;
    chk("abort_sin", 32'(sin_out), MID);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    #3 resetb = 1'b0;
    repeat (4) begin
      tick();
      chk("after_abort_done", 32'(done), 0);
      chk("after_abort_busy", 32'(busy), 0);
      chk("after_abort_sin", 32'(sin_out), MID);
    end
    start(3, 0, 1'b0);
    chk("restart_first", 32'(sin_out), 511);
    run_period(3, 0, 1'b0, 1'b0, 0, 0, -1);

    // Random chains of periods, some continued, some returning to IDLE.
    cm = $urandom_range(0, 3);
    cp = $urandom_range(0, 3);
    fd = 1'b0;
    start(cm, cp, 1'b0);
    for (int i = 0; i < 6; i++) begin
      nm = $urandom_range(0, 3);
      np = $urandom_range(0, 3);
      cn = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_period(cm, cp, fd, cn, nm, np, -1);
      if (cn) begin
        fd = 1'b1;
        cm = nm;
        cp = np;
      end else if (i < 5) begin
        fd = 1'b0;
        cm = $urandom_range(0, 3);
        cp = $urandom_range(0, 3);
        start(cm, cp, 1'b0);
      end else begin
        fd = 1'b0;
      end
    end

`ifdef WAVE_GEN_CONT_EN
    // cont starts from IDLE and chains periods; dropped mid third period.
    drive_cont = 1'b1;
    cont       = 1'b1;
    mode       = 2'd0;
    period_sel = SW'(1);
    tick();
    run_period(0, 1, 1'b0, 1'b1, 0, 1, -1);
    run_period(0, 1, 1'b1, 1'b1, 0, 1, -1);
    run_period(0, 1, 1'b1, 1'b0, 0, 0, -1);
    drive_cont = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
